// File: rtl/error_timeout_if.sv
// Error request / status bus between the datapath, the timeout controller and the display.
//   err_req      : one-cycle request to raise an error
//   err_code_in  : error code sampled with err_req (0 = no error, request ignored)
//   timeout_cfg  : configured timeout in seconds, sampled on an accepted request
//   err_clr      : user clear, sampled every cycle
//   error_code   : held error code, 0 when idle
//   error_timer  : seconds remaining, 0 when idle
//   err_active   : high while an error window is running
//   timeout_done : one-cycle pulse when the countdown expires
interface error_timeout_if;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned TIMER_W = 6;

  logic               err_req;
  logic [CODE_W-1:0]  err_code_in;
  logic [TIMER_W-1:0] timeout_cfg;
  logic               err_clr;
  logic [CODE_W-1:0]  error_code;
  logic [TIMER_W-1:0] error_timer;
  logic               err_active;
  logic               timeout_done;

  // Requester side: raises/clears errors and observes the status.
  modport master (
    output err_req, err_code_in, timeout_cfg, err_clr,
    input  error_code, error_timer, err_active, timeout_done
  );

  // Controller side.
  modport slave (
    input  err_req, err_code_in, timeout_cfg, err_clr,
    output error_code, error_timer, err_active, timeout_done
  );
endinterface

// File: rtl/error_timeout_ctrl.sv
// Error latch and seconds countdown feeding the status display.
// Latches an error code on an accepted request, counts down the configured
// (clamped) timeout in one-second ticks, and auto-clears on expiry with a
// one-cycle timeout_done pulse. A user clear ends the window early, silently.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : error_timeout_if.slave (requests in, registered status out)
module error_timeout_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned MIN_TIMEOUT = 5,
  parameter int unsigned MAX_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  error_timeout_if.slave     bus
);

  localparam int unsigned CODE_W  = 4;
  localparam int unsigned TIMER_W = 6;
  localparam int unsigned PS_W    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;

  localparam logic [TIMER_W-1:0] MIN_T   = TIMER_W'(MIN_TIMEOUT);
  localparam logic [TIMER_W-1:0] MAX_T   = TIMER_W'(MAX_TIMEOUT);
  localparam logic [PS_W-1:0]    PS_LAST = PS_W'(CLK_FREQ_HZ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               state;
  logic [PS_W-1:0]      prescaler;
  logic [CODE_W-1:0]    error_code;
  logic [TIMER_W-1:0]   error_timer;
  logic                 err_active;
  logic                 timeout_done;

  logic                 accept_c;
  logic                 wrap_c;
  logic [TIMER_W-1:0]   load_val_c;

  // A request carrying code 0 means "no error" and is ignored everywhere.
  assign accept_c = bus.err_req && (bus.err_code_in != '0);

  // One-second tick boundary.
  assign wrap_c = (prescaler == PS_LAST);

  // Unsigned 6-bit clamp of the configured timeout.
  always_comb begin
    load_val_c = bus.timeout_cfg;
    if (bus.timeout_cfg < MIN_T) begin
      load_val_c = MIN_T;
    end else if (bus.timeout_cfg > MAX_T) begin
      load_val_c = MAX_T;
    end
  end

  // State machine with registered outputs; request beats clear beats tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prescaler    <= '0;
      error_code   <= '0;
      error_timer  <= '0;
      err_active   <= 1'b0;
      timeout_done <= 1'b0;
    end else begin
      timeout_done <= 1'b0;
      case (state)
        IDLE: begin
          prescaler <= '0;
          if (accept_c) begin
            state       <= ACTIVE;
            error_code  <= bus.err_code_in;
            error_timer <= load_val_c;
            err_active  <= 1'b1;
          end
        end

        ACTIVE: begin
          if (accept_c) begin
            // Restart: newest code wins, full reload, tick phase reset.
            error_code  <= bus.err_code_in;
            error_timer <= load_val_c;
            prescaler   <= '0;
          end else if (bus.err_clr) begin
            state       <= IDLE;
            error_code  <= '0;
            error_timer <= '0;
            err_active  <= 1'b0;
            prescaler   <= '0;
          end else if (wrap_c) begin
            prescaler <= '0;
            if (error_timer > TIMER_W'(1)) begin
              error_timer <= error_timer - TIMER_W'(1);
            end else begin
              // Last second elapsed (also covers a zero timer, so no underflow).
              state        <= DONE;
              error_code   <= '0;
              error_timer  <= '0;
              err_active   <= 1'b0;
              timeout_done <= 1'b1;
            end
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end

        DONE: begin
          prescaler <= '0;
          if (accept_c) begin
            state       <= ACTIVE;
            error_code  <= bus.err_code_in;
            error_timer <= load_val_c;
            err_active  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state        <= IDLE;
          prescaler    <= '0;
          error_code   <= '0;
          error_timer  <= '0;
          err_active   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.error_code   = error_code;
  assign bus.error_timer  = error_timer;
  assign bus.err_active   = err_active;
  assign bus.timeout_done = timeout_done;

endmodule

// File: tb/tb_error_timeout_ctrl.sv
// Testbench for error_timeout_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a cycle-count reference model.
module tb_error_timeout_ctrl;

  localparam int unsigned F     = 10;
  localparam int unsigned T_MIN = 5;
  localparam int unsigned T_MAX = 15;

  logic clk;
  logic rst;

  error_timeout_if bus ();

  error_timeout_ctrl #(
    .CLK_FREQ_HZ (F),
    .MIN_TIMEOUT (T_MIN),
    .MAX_TIMEOUT (T_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Reference model: error window described by elapsed cycles since load.
  bit          m_active = 1'b0;
  int unsigned m_code   = 0;
  int unsigned m_len    = 0;
  int unsigned m_age    = 0;
  bit          m_done   = 1'b0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned clamp(input int unsigned cfg);
    if (cfg < T_MIN) return T_MIN;
    if (cfg > T_MAX) return T_MAX;
    return cfg;
  endfunction

  task automatic model_update(input bit r, input bit req, input int unsigned code,
                              input int unsigned cfg, input bit clr);
    m_done = 1'b0;
    if (r) begin
      m_active = 1'b0;
    end else if (req && code != 0) begin
      m_active = 1'b1;
      m_code   = code;
      m_len    = clamp(cfg);
      m_age    = 0;
    end else if (m_active) begin
      if (clr) begin
        m_active = 1'b0;
      end else begin
        m_age++;
        if (m_age == m_len * F) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("error_code",   32'(bus.error_code),   m_active ? m_code : 0);
    check("error_timer",  32'(bus.error_timer),  m_active ? (m_len - m_age / F) : 0);
    check("err_active",   32'(bus.err_active),   32'(m_active));
    check("timeout_done", 32'(bus.timeout_done), 32'(m_done));
  endtask

  // One clock: drive inputs, take the edge, advance the model, sample after the edge.
  task automatic step(input bit r, input bit req, input logic [3:0] code,
                      input logic [5:0] cfg, input bit clr);
    rst             = r;
    bus.err_req     = req;
    bus.err_code_in = code;
    bus.timeout_cfg = cfg;
    bus.err_clr     = clr;
    @(posedge clk);
    model_update(r, req, 32'(code), 32'(cfg), clr);
    #1;
    compare_all();
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) step(1'b0, 1'b0, 4'h0, 6'd0, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.err_req     = 1'b0;
    bus.err_code_in = '0;
    bus.timeout_cfg = '0;
    bus.err_clr     = 1'b0;
    #1;

    // Reset for two cycles.
    step(1'b1, 1'b0, 4'h0, 6'd0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 6'd0, 1'b0);
    check("reset_code", 32'(bus.error_code), 0);

    // Load code 3, 7 s; watch the full countdown.
    step(1'b0, 1'b1, 4'h3, 6'd7, 1'b0);
    check("load_timer", 32'(bus.error_timer), 7);
    idle(10);
    check("first_dec", 32'(bus.error_timer), 6);
    idle(50);
    check("last_sec", 32'(bus.error_timer), 1);
    idle(10);
    check("expire_pulse", 32'(bus.timeout_done), 1);
    check("expire_code", 32'(bus.error_code), 0);
    idle(1);
    check("pulse_width", 32'(bus.timeout_done), 0);

    // Clamp at both ends, and a zero code ignored.
    step(1'b0, 1'b1, 4'h1, 6'd2, 1'b0);
    check("clamp_low", 32'(bus.error_timer), 5);
    step(1'b0, 1'b0, 4'h0, 6'd0, 1'b1);
    step(1'b0, 1'b1, 4'h1, 6'd40, 1'b0);
    check("clamp_high", 32'(bus.error_timer), 15);
    step(1'b0, 1'b0, 4'h0, 6'd0, 1'b1);
    step(1'b0, 1'b1, 4'h0, 6'd9, 1'b0);
    check("zero_code", 32'(bus.err_active), 0);

    // Restart mid-prescaler at timer 3.
    step(1'b0, 1'b1, 4'h3, 6'd5, 1'b0);
    idle(24);
    step(1'b0, 1'b1, 4'h2, 6'd6, 1'b0);
    check("restart_timer", 32'(bus.error_timer), 6);
    idle(10);

    // Clear at timer 4 (no pulse), then clear with request together.
    step(1'b0, 1'b1, 4'h7, 6'd5, 1'b0);
    idle(12);
    step(1'b0, 1'b0, 4'h0, 6'd0, 1'b1);
    check("clr_active", 32'(bus.err_active), 0);
    step(1'b0, 1'b1, 4'h5, 6'd8, 1'b1);
    check("clr_req_code", 32'(bus.error_code), 5);

    // Reset mid-countdown, then a fresh request restarts the prescaler.
    idle(60);
    step(1'b1, 1'b0, 4'h0, 6'd0, 1'b0);
    check("rst_mid", 32'(bus.error_timer), 0);
    step(1'b0, 1'b1, 4'h9, 6'd5, 1'b0);
    idle(10);

    // Request landing exactly on the expiry cycle / a tick boundary.
    step(1'b0, 1'b1, 4'h4, 6'd5, 1'b0);
    idle(49);
    step(1'b0, 1'b1, 4'h6, 6'd5, 1'b0);
    idle(60);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(599) == 0),
           ($urandom_range(39) == 0),
           4'($urandom_range(15)),
           6'($urandom_range(63)),
           ($urandom_range(119) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
